// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS subset core: one FSM walks each instruction through FETCH/DECODE/EXEC/MEM/WB.
// Instruction and data memories are external behind req/ack handshakes, so either side may stall.
module mips_multicycle_core #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          REG_CLR  = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              retire,
    output logic              halted,
    output logic [31:0]       pc_dbg
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] ir_reg, ir_next;
    logic [31:0] a_reg, a_next;
    logic [31:0] b_reg, b_next;
    logic [31:0] alu_reg, alu_next;
    logic [31:0] mdr_reg, mdr_next;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] imm_sext, imm_zext, pc4, branch_target, jump_target, alu_result;
    logic        branch_taken;

    logic        imem_req_c, dmem_req_c, retire_c, rf_we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] rf_rd [32];

    assign op            = ir_reg[31:26];
    assign rs            = ir_reg[25:21];
    assign rt            = ir_reg[20:16];
    assign rd            = ir_reg[15:11];
    assign shamt         = ir_reg[10:6];
    assign funct         = ir_reg[5:0];
    assign imm           = ir_reg[15:0];
    assign imm_sext      = {{16{imm[15]}}, imm};
    assign imm_zext      = {16'h0000, imm};
    assign pc4           = pc_reg + 32'd4;
    assign branch_target = pc4 + {imm_sext[29:0], 2'b00};
    assign jump_target   = {pc4[31:28], ir_reg[25:0], 2'b00};
    assign branch_taken  = (op == OP_BEQ) ? (a_reg == b_reg) : (a_reg != b_reg);

    function automatic logic is_legal(input logic [5:0] opc, input logic [5:0] fn);
        logic ok;
        ok = 1'b0;
        if (opc == OP_R) begin
            case (fn)
                FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT, FN_SLL, FN_SRL: ok = 1'b1;
                default: ok = 1'b0;
            endcase
        end else begin
            case (opc)
                OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: ok = 1'b1;
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    always_comb begin
        alu_result = 32'h0;
        case (op)
            OP_R: begin
                case (funct)
                    FN_ADD:  alu_result = a_reg + b_reg;
                    FN_SUB:  alu_result = a_reg - b_reg;
                    FN_AND:  alu_result = a_reg & b_reg;
                    FN_OR:   alu_result = a_reg | b_reg;
                    FN_NOR:  alu_result = ~(a_reg | b_reg);
                    FN_SLT:  alu_result = {31'h0, $signed(a_reg) < $signed(b_reg)};
                    FN_SLL:  alu_result = b_reg << shamt;
                    FN_SRL:  alu_result = b_reg >> shamt;
                    default: alu_result = 32'h0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: alu_result = a_reg + imm_sext;
            OP_ANDI:               alu_result = a_reg & imm_zext;
            OP_ORI:                alu_result = a_reg | imm_zext;
            default:               alu_result = 32'h0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= S_FETCH;
            pc_reg    <= RESET_PC;
            ir_reg    <= 32'h0;
            a_reg     <= 32'h0;
            b_reg     <= 32'h0;
            alu_reg   <= 32'h0;
            mdr_reg   <= 32'h0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            alu_reg   <= alu_next;
            mdr_reg   <= mdr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        alu_next   = alu_reg;
        mdr_next   = mdr_reg;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        retire_c   = 1'b0;
        rf_we      = 1'b0;
        case (state_reg)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ack) begin
                    ir_next    = imem_rdata;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                a_next = rf_rd[rs];
                b_next = rf_rd[rt];
                if (!is_legal(op, funct)) begin
                    state_next = S_HALT;
                end else if (op == OP_J) begin
                    pc_next    = jump_target;
                    retire_c   = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_next = alu_result;
                if (op == OP_BEQ || op == OP_BNE) begin
                    pc_next    = branch_taken ? branch_target : pc4;
                    retire_c   = 1'b1;
                    state_next = S_FETCH;
                end else if (op == OP_LW || op == OP_SW) begin
                    state_next = (alu_result[1:0] != 2'b00) ? S_HALT : S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                if (dmem_ack) begin
                    if (op == OP_SW) begin
                        pc_next    = pc4;
                        retire_c   = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        mdr_next   = dmem_rdata;
                        state_next = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we      = 1'b1;
                pc_next    = pc4;
                retire_c   = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT: state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
    end

    assign wr_addr = (op == OP_R) ? rd : rt;
    assign wr_data = (op == OP_LW) ? mdr_reg : alu_reg;

    // r0 is hardwired; r1..r31 optionally survive reset when REG_CLR is 0.
    assign rf_rd[0] = 32'h0;
    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_rf
            logic [31:0] q_reg;
            always_ff @(posedge clock) begin
                if (!reset) begin
                    if (REG_CLR) q_reg <= 32'h0;
                end else if (rf_we && wr_addr == 5'(gi)) begin
                    q_reg <= wr_data;
                end
            end
            assign rf_rd[gi] = q_reg;
        end
    endgenerate

    // Requests are masked while reset is low so an abandoned transfer drops at once.
    assign imem_req   = imem_req_c & reset;
    assign imem_addr  = pc_reg[ADDR_W-1:0];
    assign dmem_req   = dmem_req_c & reset;
    assign dmem_we    = dmem_req & (op == OP_SW);
    assign dmem_addr  = dmem_req ? alu_reg[ADDR_W-1:0] : '0;
    assign dmem_wdata = dmem_req ? b_reg : 32'h0;
    assign retire     = retire_c & reset;
    assign halted     = (state_reg == S_HALT) & reset;
    assign pc_dbg     = pc_reg;

endmodule
